// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: FSM encodings, PC step and
// queue entry layout {pc, taken, target} packed MSB-first.
package branch_resolve_unit_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  localparam int unsigned PC_INC = 4;

  function automatic int unsigned entry_w(input int unsigned xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// In-order prediction FIFO with push, pop and clear. Pointers carry one extra
// wrap bit so a full queue and an empty queue are distinguishable.
module pred_queue #(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  input  logic         i_clear,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]  wr_q, wr_d;
  logic [PW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign o_head  = mem_q[rd_q[PW-1:0]];

  // Clear wins over push/pop: the queue collapses to empty at the write pointer.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (i_clear) begin
      rd_d = wr_q;
    end else begin
      if (i_push && !o_full)  wr_d = wr_q + (PW+1)'(1);
      if (i_pop  && !o_empty) rd_d = rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full && !i_clear) mem_q[wr_q[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares resolved branch outcomes against queued fetch predictions, raises a
// registered flush/redirect on mispredict and emits training updates and stats.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pred_valid,
  output logic             o_pred_ready,
  input  logic [XLEN-1:0]  i_pred_pc,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_pred_target,
  input  logic             i_res_valid,
  input  logic [XLEN-1:0]  i_res_pc,
  input  logic             i_res_taken,
  input  logic [XLEN-1:0]  i_res_target,
  output logic             o_flush,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_upd_valid,
  output logic [XLEN-1:0]  o_upd_pc,
  output logic             o_upd_taken,
  output logic [XLEN-1:0]  o_upd_target,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispredict_cnt,
  output logic             o_dbg_state
);

  localparam int unsigned EW = entry_w(XLEN);

  // Handshake: a prediction is accepted on a cycle where i_pred_valid and
  // o_pred_ready are both high; o_pred_ready depends only on registered state.
  state_e            state_q, state_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   redirect_q, redirect_d;
  logic              upd_valid_q, upd_valid_d;
  logic [XLEN-1:0]   upd_pc_q, upd_pc_d;
  logic              upd_taken_q, upd_taken_d;
  logic [XLEN-1:0]   upd_target_q, upd_target_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  logic            q_full, q_empty, q_push, q_pop, q_clear;
  logic [EW-1:0]   q_head;
  logic [XLEN-1:0] head_pc, head_target, head_inc, res_inc, pred_next, act_next;
  logic            head_taken, res_acc, mispredict;

  pred_queue #(.W(EW), .DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (q_push),
    .i_data  ({i_pred_pc, i_pred_taken, i_pred_target}),
    .i_pop   (q_pop),
    .i_clear (q_clear),
    .o_full  (q_full),
    .o_empty (q_empty),
    .o_head  (q_head)
  );

  assign head_pc     = q_head[EW-1:XLEN+1];
  assign head_taken  = q_head[XLEN];
  assign head_target = q_head[XLEN-1:0];
  assign head_inc    = head_pc + XLEN'(PC_INC);
  assign res_inc     = i_res_pc + XLEN'(PC_INC);

  // An empty queue behaves as a not-taken prediction for the resolving branch.
  assign pred_next  = q_empty ? res_inc : (head_taken ? head_target : head_inc);
  assign act_next   = i_res_taken ? i_res_target : res_inc;
  assign res_acc    = i_res_valid && (state_q == ST_RUN);
  assign mispredict = res_acc && (q_empty ? i_res_taken
                                          : ((head_pc != i_res_pc) || (pred_next != act_next)));

  assign o_pred_ready = !q_full && (state_q == ST_RUN);
  assign q_push       = i_pred_valid && o_pred_ready && !mispredict;
  assign q_pop        = res_acc && !q_empty;
  assign q_clear      = mispredict;

  always_comb begin
    state_d      = ST_RUN;
    flush_d      = mispredict;
    redirect_d   = mispredict ? act_next : redirect_q;
    upd_valid_d  = res_acc;
    upd_pc_d     = res_acc ? i_res_pc     : upd_pc_q;
    upd_taken_d  = res_acc ? i_res_taken  : upd_taken_q;
    upd_target_d = res_acc ? i_res_target : upd_target_q;
    branch_cnt_d = branch_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (state_q == ST_RUN && mispredict) state_d = ST_RECOVER;
    if (res_acc && branch_cnt_q != '1)   branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (mispredict && mis_cnt_q != '1)   mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
      upd_target_q <= upd_target_d;
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign o_flush          = flush_q;
  assign o_redirect_pc    = redirect_q;
  assign o_upd_valid      = upd_valid_q;
  assign o_upd_pc         = upd_pc_q;
  assign o_upd_taken      = upd_taken_q;
  assign o_upd_target     = upd_target_q;
  assign o_branch_cnt     = branch_cnt_q;
  assign o_mispredict_cnt = mis_cnt_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: resolves are queued as expected update records and a
// negedge monitor pops and compares them whenever o_upd_valid is seen.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int EXP_W = 2 + 3 * XLEN;

  logic             clk;
  logic             rst_n;
  logic             i_pred_valid, o_pred_ready, i_pred_taken;
  logic [XLEN-1:0]  i_pred_pc, i_pred_target;
  logic             i_res_valid, i_res_taken;
  logic [XLEN-1:0]  i_res_pc, i_res_target;
  logic             o_flush, o_upd_valid, o_upd_taken, o_dbg_state;
  logic [XLEN-1:0]  o_redirect_pc, o_upd_pc, o_upd_target;
  logic [CNT_W-1:0] o_branch_cnt, o_mispredict_cnt;

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_pred_valid     (i_pred_valid),
    .o_pred_ready     (o_pred_ready),
    .i_pred_pc        (i_pred_pc),
    .i_pred_taken     (i_pred_taken),
    .i_pred_target    (i_pred_target),
    .i_res_valid      (i_res_valid),
    .i_res_pc         (i_res_pc),
    .i_res_taken      (i_res_taken),
    .i_res_target     (i_res_target),
    .o_flush          (o_flush),
    .o_redirect_pc    (o_redirect_pc),
    .o_upd_valid      (o_upd_valid),
    .o_upd_pc         (o_upd_pc),
    .o_upd_taken      (o_upd_taken),
    .o_upd_target     (o_upd_target),
    .o_branch_cnt     (o_branch_cnt),
    .o_mispredict_cnt (o_mispredict_cnt),
    .o_dbg_state      (o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  logic [XLEN-1:0]  last_redir = '0;
  int exp_branch = 0;
  int exp_mis    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: record layout {flush, redirect, pc, taken, target}
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_upd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_update: got pc %0h with no pending resolve", o_upd_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("upd_pc",      o_upd_pc,      mon_e[2*XLEN:XLEN+1]);
          check("upd_taken",   o_upd_taken,   mon_e[XLEN]);
          check("upd_target",  o_upd_target,  mon_e[XLEN-1:0]);
          check("flush",       o_flush,       mon_e[EXP_W-1]);
          check("redirect_pc", o_redirect_pc, mon_e[EXP_W-2:2*XLEN+1]);
        end
      end else begin
        check("flush_without_update", o_flush, 1'b0);
      end
    end
  end

  // Driver tasks
  task automatic cyc(input logic pv, input logic [XLEN-1:0] ppc, input logic pt,
                     input logic [XLEN-1:0] ptg, input logic rv, input logic [XLEN-1:0] rpc,
                     input logic rt, input logic [XLEN-1:0] rtg);
    i_pred_valid = pv; i_pred_pc = ppc; i_pred_taken = pt; i_pred_target = ptg;
    i_res_valid  = rv; i_res_pc  = rpc; i_res_taken  = rt; i_res_target  = rtg;
    @(posedge clk);
    #1;
    i_pred_valid = 1'b0;
    i_res_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic t, input logic [XLEN-1:0] tg);
    cyc(1, pc, t, tg, 0, 0, 0, 0);
  endtask

  task automatic expect_res(input logic [XLEN-1:0] pc, input logic t, input logic [XLEN-1:0] tg,
                            input logic fl, input logic [XLEN-1:0] redir);
    if (fl) begin
      last_redir = redir;
      exp_mis++;
    end
    exp_branch++;
    exp_q.push_back({fl, last_redir, pc, t, tg});
  endtask

  task automatic resolve(input logic [XLEN-1:0] pc, input logic t, input logic [XLEN-1:0] tg,
                         input logic fl, input logic [XLEN-1:0] redir);
    expect_res(pc, t, tg, fl, redir);
    cyc(0, 0, 0, 0, 1, pc, t, tg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    i_pred_valid = 0; i_pred_pc = 0; i_pred_taken = 0; i_pred_target = 0;
    i_res_valid  = 0; i_res_pc  = 0; i_res_taken  = 0; i_res_target  = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush",    o_flush, 0);
    check("rst_upd",      o_upd_valid, 0);
    check("rst_redirect", o_redirect_pc, 0);
    check("rst_bcnt",     o_branch_cnt, 0);
    check("rst_mcnt",     o_mispredict_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", o_pred_ready, 1);

    // Correct taken prediction
    push(32'h100, 1, 32'h200);
    resolve(32'h100, 1, 32'h200, 0, 0);
    check("t1_bcnt", o_branch_cnt, 1);
    check("t1_mcnt", o_mispredict_cnt, 0);

    // Direction mispredict, second entry must be squashed
    push(32'h100, 0, 0);
    push(32'h104, 0, 0);
    resolve(32'h100, 1, 32'h300, 1, 32'h300);
    check("t2_recover_ready", o_pred_ready, 0);
    check("t2_recover_state", o_dbg_state, 1);
    check("t2_flush",         o_flush, 1);
    check("t2_redirect",      o_redirect_pc, 32'h300);
    idle(1);
    check("t2_ready_back", o_pred_ready, 1);
    check("t2_mcnt",       o_mispredict_cnt, 1);
    resolve(32'h700, 0, 0, 0, 0);

    // Predicted taken, actually not taken
    push(32'h40, 1, 32'h80);
    resolve(32'h40, 0, 0, 1, 32'h44);
    idle(1);

    // Fill, then pop with a blocked push
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 16), 0, 0);
    check("t4_full_ready", o_pred_ready, 0);
    expect_res(32'h1000, 0, 0, 0, 0);
    cyc(1, 32'h2000, 0, 0, 1, 32'h1000, 0, 0);
    check("t4_occ3_ready", o_pred_ready, 1);
    push(32'h1040, 0, 0);
    check("t4_refull_ready", o_pred_ready, 0);
    for (int i = 1; i < 5; i++) resolve(32'h1000 + 32'(i * 16), 0, 0, 0, 0);
    check("t4_drained_ready", o_pred_ready, 1);

    // Pointer wrap with simultaneous push/pop
    push(32'h3000, 0, 32'h6000);
    for (int i = 0; i < 10; i++) begin
      expect_res(32'h3000 + 32'(i * 16), i[0], 32'h6000 + 32'(i * 8), 0, 0);
      cyc(1, 32'h3000 + 32'((i + 1) * 16), ~i[0], 32'h6000 + 32'((i + 1) * 8),
          1, 32'h3000 + 32'(i * 16), i[0], 32'h6000 + 32'(i * 8));
    end
    resolve(32'h30a0, 0, 32'h6050, 0, 0);

    // Empty-queue resolves
    resolve(32'h500, 1, 32'h600, 1, 32'h600);
    idle(1);
    resolve(32'h500, 0, 0, 0, 0);
    idle(1);
    check("t5_redirect_hold", o_redirect_pc, 32'h600);
    check("bcnt_total", o_branch_cnt, exp_branch);
    check("mcnt_total", o_mispredict_cnt, exp_mis);
    idle(2);

    // Asynchronous reset with entries queued
    push(32'h9000, 0, 0);
    push(32'h9010, 0, 0);
    push(32'h9020, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_flush", o_flush, 0);
    check("arst_upd",   o_upd_valid, 0);
    check("arst_bcnt",  o_branch_cnt, 0);
    check("arst_mcnt",  o_mispredict_cnt, 0);
    check("arst_state", o_dbg_state, 0);
    exp_branch = 0;
    exp_mis    = 0;
    last_redir = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", o_pred_ready, 1);
    resolve(32'h9010, 0, 0, 0, 0);
    check("post_rst_bcnt", o_branch_cnt, 1);
    check("post_rst_mcnt", o_mispredict_cnt, 0);
    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer side of the branch-prediction interface: sits between the fetch-stage predictor and the decode/execute branch comparator.
- Records every prediction issued at fetch in an in-order queue.
- When the actual branch outcome arrives, compares it against the oldest prediction. On mismatch it raises a one-cycle flush with the corrected fetch PC.
- For every resolved branch it emits a training update (branch PC, actual direction, actual target) back to the predictor, and keeps prediction statistics.

Parameters:
- XLEN, 32, address/PC width (matches `N from parameters.vh).
- DEPTH, 4, in-flight prediction queue entries (power of two, ≥2).
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_pred_valid  in  1  fetch issued a prediction for a branch this cycle.
- o_pred_ready  out  1  queue can accept a prediction.
- i_pred_pc  in  XLEN  PC of predicted branch.
- i_pred_taken  in  1  predicted direction.
- i_pred_target  in  XLEN  predicted target (ignored if not taken).
- i_res_valid  in  1  branch outcome resolved this cycle (program order).
- i_res_pc  in  XLEN  PC of resolved branch.
- i_res_taken  in  1  actual direction.
- i_res_target  in  XLEN  actual taken target.
- o_flush  out  1  one-cycle pulse: squash younger instructions.
- o_redirect_pc  out  XLEN  corrected fetch PC, valid with o_flush.
- o_upd_valid  out  1  one-cycle training pulse to predictor.
- o_upd_pc  out  XLEN  branch PC for training.
- o_upd_taken  out  1  actual direction for training.
- o_upd_target  out  XLEN  actual target for training.
- o_branch_cnt  out  CNT_W  resolved-branch count.
- o_mispredict_cnt  out  CNT_W  mispredict count.

Behaviour:
- Reset (async, rst_n=0): queue empty, state RUN, all outputs 0, counters 0. Reset mid-operation discards all queued entries immediately.
- Queue: circular FIFO, entries {pc, taken, target}. Pointers are log2(DEPTH)+1 bits so full and empty are distinguishable; wrap modulo DEPTH.
- o_pred_ready = !full && state==RUN. This is combinational; push happens on i_pred_valid && o_pred_ready.
- Resolve: on i_res_valid in RUN, pop the head and compare.
- Predicted next PC:
  - Head present: head.taken ? head.target : head.pc+4.
  - Queue empty: treated as predicted not-taken, i.e. i_res_pc+4.
- Actual next PC = i_res_taken ? i_res_target : i_res_pc+4. All +4 arithmetic wraps modulo 2^XLEN.
- Mispredict if:
  - queue empty with i_res_taken=1, or
  - head.pc != i_res_pc (ordering loss, treated as mispredict), or
  - predicted next PC != actual next PC.
- Latency: all resolve outputs are registered and appear the cycle after i_res_valid.
  - o_upd_valid pulses for every resolve; o_upd_pc/taken/target carry the i_res_* values.
  - On mispredict, o_flush=1 and o_redirect_pc = actual next PC for one cycle.
  - Otherwise o_flush=0 and o_redirect_pc holds its last value.
- FSM:
  - RUN: normal operation. A mispredicting resolve clears the queue (rd=wr) next edge and moves to RECOVER.
  - RECOVER: exactly one cycle; coincides with the o_flush pulse. o_pred_ready=0, i_res_valid is ignored (no update, no count). Returns to RUN.
- Simultaneous push and resolve in RUN:
  - Correct resolve: both occur; occupancy unchanged. A push is allowed even when full if a pop happens the same cycle? No: ready uses the registered full, so no push when full.
  - Mispredicting resolve: the push is dropped (it is wrong-path); queue ends empty.
- Counters: o_branch_cnt increments on every accepted resolve. o_mispredict_cnt increments on each mispredict. Both saturate at all-ones.
- i_pred_valid while not ready: the prediction is lost. Fetch must hold or stall; no error flag.

Decomposition:
- Shared package/header (extend parameters.vh): RUN/RECOVER state encodings, PC increment constant 4, entry field layout macro.
- One natural sub-module: pred_queue (parameterised sync FIFO with push, pop and clear, exposing full, empty and head). The comparator, FSM and counters stay in the top module.

Test Plan:
- Push {pc=0x100, T, tgt=0x200}; resolve {0x100, T, 0x200} → next cycle o_upd_valid=1, o_flush=0; branch_cnt=1, mispredict_cnt=0.
- Push {0x100, NT}; resolve {0x100, T, 0x300} → o_flush=1, o_redirect_pc=0x300; next cycle o_pred_ready=0 (RECOVER); queue empty afterwards; mispredict_cnt=1.
- Push {0x40, T, 0x80}; resolve {0x40, NT} → o_flush=1, o_redirect_pc=0x44.
- Fill 4 entries → o_pred_ready=0. Then same cycle pop (correct) + push attempt → no push accepted; occupancy 3 next cycle; pointer wrap verified over 10 push/pop pairs.
- Resolve with empty queue {0x500, T, 0x600} → flush to 0x600. Resolve with empty queue {0x500, NT} → no flush, update pulse only.
- 3 entries queued, assert rst_n=0 mid-cycle → outputs and counters 0 immediately; after release o_pred_ready=1 and queue is empty.
